// File: rtl/emif_async_master.sv
// Asynchronous 16-bit EMIF bus initiator: turns single-word read/write requests into
// CE/WE/OE bus cycles with programmable setup, strobe, hold and turnaround phases.
module emif_async_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned TA_CYC     = 2
) (
    input  logic        clk_100m,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [1:0]  req_byten,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        emif_cen_o,
    output logic        emif_wen_o,
    output logic        emif_oen_o,
    output logic [23:0] emif_addr_o,
    output logic [1:0]  emif_byten_o,
    output logic [15:0] emif_data_o,
    output logic        emif_data_oe,
    input  logic [15:0] emif_data_i
);

    if (SETUP_CYC < 1 || SETUP_CYC > 15 || STROBE_CYC < 3 || STROBE_CYC > 15 ||
        HOLD_CYC < 1 || HOLD_CYC > 15 || TA_CYC < 1 || TA_CYC > 15) begin : gen_param_check
        $error("emif_async_master: illegal phase length parameter");
    end

    localparam logic [3:0] SetupLd  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] StrobeLd = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HoldLd   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] TaLd     = 4'(TA_CYC - 1);

    typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StTa} state_e;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       wr_q;

    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= 16'h0000;
            emif_cen_o   <= 1'b1;
            emif_wen_o   <= 1'b1;
            emif_oen_o   <= 1'b1;
            emif_addr_o  <= 24'h000000;
            emif_byten_o <= 2'b11;
            emif_data_o  <= 16'h0000;
            emif_data_oe <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        state_q      <= StSetup;
                        cnt_q        <= SetupLd;
                        wr_q         <= req_wr;
                        emif_cen_o   <= 1'b0;
                        // Rotated right; the slave rotates left to recover the word address.
                        emif_addr_o  <= {req_addr[0], req_addr[23:1]};
                        emif_byten_o <= req_byten;
                        emif_data_oe <= req_wr;
                        if (req_wr) begin
                            emif_data_o <= req_wdata;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= StStrobe;
                        cnt_q      <= StrobeLd;
                        emif_wen_o <= ~wr_q;
                        emif_oen_o <= wr_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StStrobe: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= StHold;
                        cnt_q      <= HoldLd;
                        emif_wen_o <= 1'b1;
                        emif_oen_o <= 1'b1;
                        if (!wr_q) begin
                            rd_data  <= emif_data_i;
                            rd_valid <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StHold: begin
                    if (cnt_q == 4'd0) begin
                        state_q      <= StTa;
                        cnt_q        <= TaLd;
                        emif_cen_o   <= 1'b1;
                        emif_byten_o <= 2'b11;
                        emif_data_oe <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StTa: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_emif_async_master.sv
// Bench for emif_async_master: per-cycle timing checks plus read and slave-side write scoreboards.
module tb_emif_async_master;

    logic clk_100m = 1'b0;
    always #5 clk_100m = ~clk_100m;

    logic        rst_n;
    logic        req_valid, req_wr, req_ready, rd_valid, busy;
    logic [23:0] req_addr, emif_addr_o;
    logic [15:0] req_wdata, rd_data, emif_data_o, emif_data_i;
    logic [1:0]  req_byten, emif_byten_o;
    logic        emif_cen_o, emif_wen_o, emif_oen_o, emif_data_oe;

    logic        f_req_valid, f_req_wr, f_req_ready, f_rd_valid, f_busy;
    logic [23:0] f_req_addr, f_addr;
    logic [15:0] f_req_wdata, f_rd_data, f_data_o;
    logic [1:0]  f_req_byten, f_byten;
    logic        f_cen, f_wen, f_oen, f_data_oe;

    logic [15:0] pin_val;
    assign emif_data_i = !emif_oen_o ? pin_val : 16'hDEAD;

    emif_async_master u_dut (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_byten(req_byten), .rd_valid(rd_valid), .rd_data(rd_data),
        .busy(busy), .emif_cen_o(emif_cen_o), .emif_wen_o(emif_wen_o), .emif_oen_o(emif_oen_o),
        .emif_addr_o(emif_addr_o), .emif_byten_o(emif_byten_o), .emif_data_o(emif_data_o),
        .emif_data_oe(emif_data_oe), .emif_data_i(emif_data_i)
    );

    emif_async_master #(.SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1), .TA_CYC(1)) u_dut_fast (
        .clk_100m(clk_100m), .rst_n(rst_n),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_wr(f_req_wr),
        .req_addr(f_req_addr), .req_wdata(f_req_wdata), .req_byten(f_req_byten),
        .rd_valid(f_rd_valid), .rd_data(f_rd_data), .busy(f_busy),
        .emif_cen_o(f_cen), .emif_wen_o(f_wen), .emif_oen_o(f_oen), .emif_addr_o(f_addr),
        .emif_byten_o(f_byten), .emif_data_o(f_data_o), .emif_data_oe(f_data_oe),
        .emif_data_i(16'h0000)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [15:0] rd_sb[$];
    logic [39:0] wr_sb[$];
    int          rdv_cnt = 0;
    int          slv_cnt = 0;
    int          viol    = 0;

    // Read scoreboard and strobe-exclusivity checker for both instances.
    always @(negedge clk_100m) begin
        if ((!emif_wen_o && !emif_oen_o) || (emif_cen_o && (!emif_wen_o || !emif_oen_o))) viol++;
        if ((!f_wen && !f_oen) || (f_cen && (!f_wen || !f_oen))) viol++;
        if (rd_valid) begin
            rdv_cnt++;
            if (rd_sb.size() == 0) check("rd_unexpected", 32'(rd_sb.size()), 1);
            else check("rd_data", {16'h0, rd_data}, {16'h0, rd_sb.pop_front()});
        end
    end

    // Slave capture model: synchronised WE falling edge, address rotated back left.
    logic [2:0] sw_sync = 3'b111;
    always @(negedge clk_100m) begin
        logic [39:0] e;
        if (sw_sync[2:1] == 2'b10 && !emif_cen_o && emif_byten_o == 2'b00) begin
            slv_cnt++;
            if (wr_sb.size() == 0) begin
                check("slv_unexpected", 32'(wr_sb.size()), 1);
            end else begin
                e = wr_sb.pop_front();
                check("slv_addr", {8'h0, emif_addr_o[22:0], emif_addr_o[23]}, {8'h0, e[39:16]});
                check("slv_data", {16'h0, emif_data_o}, {16'h0, e[15:0]});
            end
        end
        sw_sync <= {sw_sync[1:0], emif_wen_o};
    end

    task automatic wait_ready();
        int guard = 0;
        @(negedge clk_100m);
        while (!req_ready && guard < 100) begin
            @(negedge clk_100m);
            guard++;
        end
        if (!req_ready) check("ready_timeout", {31'b0, req_ready}, 1);
    endtask

    task automatic run_txn(input logic wr, input logic [23:0] a, input logic [15:0] wd,
                           input logic [1:0] be, output int cen_n, output int wen_n,
                           output int oen_n, output int oe_n, output int rdv_at,
                           output int rdy_at, output logic [23:0] bus_addr);
        cen_n = 0; wen_n = 0; oen_n = 0; oe_n = 0; rdv_at = 0; rdy_at = 0; bus_addr = '0;
        wait_ready();
        req_wr = wr; req_addr = a; req_wdata = wd; req_byten = be; req_valid = 1'b1;
        if (wr && be == 2'b00) wr_sb.push_back({a, wd});
        if (!wr) rd_sb.push_back(pin_val);
        @(posedge clk_100m);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk_100m);
            if (!emif_cen_o) cen_n++;
            if (!emif_wen_o) wen_n++;
            if (!emif_oen_o) oen_n++;
            if (emif_data_oe) oe_n++;
            if (rd_valid && rdv_at == 0) rdv_at = n;
            if (req_ready && rdy_at == 0) rdy_at = n;
            if (n == 1) bus_addr = emif_addr_o;
        end
    endtask

    initial begin
        int          cn, wn, on, oe, rv, ry, rv0, s0, gap, n, fb, fw;
        logic [23:0] ba;
        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        req_byten = 2'b11; pin_val = 16'h0;
        f_req_valid = 1'b0; f_req_wr = 1'b0; f_req_addr = '0; f_req_wdata = '0;
        f_req_byten = 2'b11;
        #22;
        check("rst_cen", {31'b0, emif_cen_o}, 1);
        check("rst_wen_oen", {30'b0, emif_wen_o, emif_oen_o}, 3);
        check("rst_byten", {30'b0, emif_byten_o}, 3);
        check("rst_addr", {8'h0, emif_addr_o}, 0);
        check("rst_data", {15'h0, emif_data_oe, emif_data_o}, 0);
        check("rst_rd", {14'h0, busy, rd_valid, rd_data}, 0);
        @(negedge clk_100m) rst_n = 1'b1;
        @(negedge clk_100m) check("ready_after_rst", {31'b0, req_ready}, 1);

        // Default write.
        run_txn(1'b1, 24'h123456, 16'hA5C3, 2'b00, cn, wn, on, oe, rv, ry, ba);
        check("wr_cen_len", cn, 8);
        check("wr_wen_len", wn, 4);
        check("wr_oen_len", on, 0);
        check("wr_data_oe_len", oe, 8);
        check("wr_bus_addr", {8'h0, ba}, 32'h091A2B);
        check("wr_ready_at", ry, 11);

        // Default read.
        pin_val = 16'h5AA5;
        rv0 = rdv_cnt;
        run_txn(1'b0, 24'h000001, 16'h0, 2'b00, cn, wn, on, oe, rv, ry, ba);
        check("rd_bus_addr", {8'h0, ba}, 32'h800000);
        check("rd_valid_at", rv, 7);
        check("rd_valid_pulses", rdv_cnt - rv0, 1);
        check("rd_data_oe", oe, 0);
        check("rd_oen_len", on, 4);
        check("rd_wen_len", wn, 0);

        // Back-to-back write then read, req_valid held high throughout.
        wait_ready();
        req_wr = 1'b1; req_addr = 24'h00BEEF; req_wdata = 16'h1357; req_byten = 2'b00;
        req_valid = 1'b1;
        wr_sb.push_back({24'h00BEEF, 16'h1357});
        @(posedge clk_100m);
        #1 req_wr = 1'b0; req_addr = 24'h00ABCD; pin_val = 16'h2468;
        rd_sb.push_back(16'h2468);
        gap = 0; n = 0;
        while (n < 30) begin
            @(negedge clk_100m);
            n++;
            if (emif_cen_o) gap++;
            if (req_ready) break;
        end
        check("b2b_ready_at", n, 11);
        check("b2b_cen_gap_ok", {31'b0, gap >= 2}, 1);
        @(negedge clk_100m);
        req_valid = 1'b0;
        check("b2b_second_accept", {30'b0, busy, emif_cen_o}, 2);
        wait_ready();

        // Random writes seen by the slave model, then one masked write it must ignore.
        s0 = slv_cnt;
        for (int i = 0; i < 16; i++) begin
            run_txn(1'b1, 24'($urandom), 16'($urandom), 2'b00, cn, wn, on, oe, rv, ry, ba);
        end
        check("slv_16_writes", slv_cnt - s0, 16);
        s0 = slv_cnt;
        run_txn(1'b1, 24'h00F00D, 16'hCAFE, 2'b01, cn, wn, on, oe, rv, ry, ba);
        check("slv_byten01_ignored", slv_cnt - s0, 0);
        check("byten01_cycle_ran", wn, 4);

        // Minimum-timing instance.
        fb = 0; fw = 0;
        f_req_wr = 1'b1; f_req_addr = 24'h000010; f_req_wdata = 16'h0F0F; f_req_byten = 2'b00;
        @(negedge clk_100m);
        check("fast_ready", {31'b0, f_req_ready}, 1);
        f_req_valid = 1'b1;
        @(posedge clk_100m);
        #1 f_req_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_100m);
            if (f_busy) fb++;
            if (!f_wen) fw++;
        end
        check("fast_busy_len", fb, 6);
        check("fast_strobe_len", fw, 3);

        // Reset during the second STROBE cycle of a read.
        wait_ready();
        pin_val = 16'h7777;
        rv0 = rdv_cnt;
        req_wr = 1'b0; req_addr = 24'h000100; req_byten = 2'b00; req_valid = 1'b1;
        @(posedge clk_100m);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk_100m);
        check("rst_mid_in_strobe", {31'b0, emif_oen_o}, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cen", {31'b0, emif_cen_o}, 1);
        check("rst_mid_oen", {31'b0, emif_oen_o}, 1);
        check("rst_mid_data_oe", {31'b0, emif_data_oe}, 0);
        check("rst_mid_busy", {31'b0, busy}, 0);
        repeat (3) @(negedge clk_100m);
        rst_n = 1'b1;
        repeat (10) @(negedge clk_100m);
        check("rst_mid_no_rd_valid", rdv_cnt - rv0, 0);
        check("rst_mid_ready", {31'b0, req_ready}, 1);

        check("wr_sb_drained", 32'(wr_sb.size()), 0);
        check("rd_sb_drained", 32'(rd_sb.size()), 0);
        check("strobe_exclusive", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/emif_async_master.md
# emif_async_master

FPGA-side initiator for the asynchronous 16-bit EMIF bus. It turns single-word read/write requests from local logic into EMIF bus cycles (CE, WE, OE, address, byte enables, data) with parameterised setup, strobe, hold and turnaround phases. It sits between an internal command source (test sequencer, DMA, bench driver) and the EMIF pins. It is the counterpart of the EMIF slave capture path, so its address mapping and minimum strobe timing are matched to that path.

## Interface
Parameters:
- SETUP_CYC, 2, cycles CE/addr/byten valid before strobe falls (legal 1..15)
- STROBE_CYC, 4, cycles WE or OE held low (legal 3..15; 3 is the slave's minimum sync+edge-detect window)
- HOLD_CYC, 2, cycles CE/addr/data held after strobe rises (legal 1..15)
- TA_CYC, 2, cycles CE high, bus released, before next request is accepted (legal 1..15)

Ports:
- clk_100m  in  1  clock, 100 MHz
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; transfer on req_valid&&req_ready
- req_wr  in  1  1 = write, 0 = read
- req_addr  in  24  logical word address
- req_wdata  in  16  write data
- req_byten  in  2  active-low byte enables
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  16  read data
- busy  out  1  state != IDLE
- emif_cen_o / emif_wen_o / emif_oen_o  out  1 each  active-low chip enable / write strobe / output enable
- emif_addr_o  out  24  bus address
- emif_byten_o  out  2  bus byte enables
- emif_data_o  out  16  write data
- emif_data_oe  out  1  tristate enable for emif_data_o
- emif_data_i  in  16  read data from pins

## Operation
- FSM: IDLE -> SETUP -> STROBE -> HOLD -> TA -> IDLE. One 4-bit phase counter is loaded with (phase length - 1) on entry and decremented each cycle. The phase exits when the counter is 0.
- On accept, register req_wr, req_byten and req_wdata. Also register the address rotated right by one: emif_addr_o = {req_addr[0], req_addr[23:1]}. The slave rotates the address left by one, so it recovers req_addr.
- All bus outputs are registered, with no combinational path from req_* to the pins.
- SETUP:
  - cen=0, addr and byten driven, wen=oen=1.
  - Write: data_oe=1, data_o=wdata.
- STROBE: as SETUP, plus wen=0 (write) or oen=0 (read).
- Read data: on the clock edge that ends the last STROBE cycle, capture emif_data_i into rd_data. rd_valid pulses in the first HOLD cycle.
- HOLD: wen=oen=1. cen, addr, byten and (write) data/data_oe are unchanged.
- TA:
  - cen=1, byten=2'b11, data_oe=0.
  - data_o and addr keep their last value.
- Illegal parameter values (0, or STROBE_CYC<3) are a synthesis-time error, enforced by an elaboration check.
- byten is passed through unchanged. A value other than 2'b00 produces a legal bus cycle that the slave ignores; this is not an error here.

## Timing
- Reset values: cen=wen=oen=1, byten=2'b11, addr=0, data_o=0, data_oe=0, rd_valid=0, rd_data=0, busy=0, state=IDLE.
- After reset release, req_ready=1.
- Accept edge T0. SETUP occupies cycles T1..T(S). STROBE follows for STROBE_CYC cycles, then HOLD for HOLD_CYC cycles, then TA for TA_CYC cycles. IDLE is re-entered and req_ready rises at T(S+ST+H+TA+1).
- Defaults give 10 busy cycles per transaction plus 1 IDLE cycle, so the sustained rate is 1 transaction per 11 cycles.
- rd_valid latency from the accept edge is SETUP_CYC+STROBE_CYC+1 cycles (7 with defaults).
- Only one of wen and oen is ever low, and never while cen=1.
- req_valid during busy is ignored and not queued; the source must hold it until req_ready.
- Reset mid-operation: all outputs return asynchronously to their reset values. The transaction is dropped and no rd_valid is emitted.

## Test plan
- Write with defaults, addr=0x123456, wdata=0xA5C3, byten=00:
  - cen low for 8 cycles; wen low for exactly 4.
  - emif_addr_o=0x091A2B; data_oe high SETUP..HOLD.
  - req_ready returns 11 cycles after accept.
- Read with defaults, addr=0x000001, pin model drives 0x5AA5 while oen=0:
  - emif_addr_o=0x800000.
  - rd_valid is a single pulse 7 cycles after accept, rd_data=0x5AA5; data_oe stays 0.
- Back-to-back write then read with req_valid held high:
  - second accept occurs exactly at the req_ready rise.
  - ≥TA_CYC cycles of cen=1 between the cycles; wen/oen never both low.
- Params SETUP=1, STROBE=3, HOLD=1, TA=1: write cycle busy is 6 cycles; strobe width is 3.
- rst_n asserted during the 2nd STROBE cycle of a read:
  - outputs immediately reset: cen=1, oen=1, data_oe=0.
  - no rd_valid; req_ready=1 after release.
- Loopback against the EMIF slave capture logic: 16 random writes with byten=00 produce 16 slave write strobes with matching address and data. A write with byten=01 produces none.
